// File: rtl/mul_add_seq_uns.sv
// rtl/mul_add_seq_uns.sv - sequential radix-2 shift-add recomposition X = Q*Y + R (unsigned)
module mul_add_seq_uns #(
    parameter int widthX = 16,
    parameter int widthY = 8,
    localparam int widthQ = widthX - widthY + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [widthQ-1:0] Q_i,
    input  logic [widthY-1:0] Y_i,
    input  logic [widthY-1:0] R_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [widthX:0]   X_o,
    output logic              ovf_o,
    output logic              rem_ge_y_o,
    output logic              busy_o
);

    localparam int CW = (widthQ > 1) ? $clog2(widthQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(widthQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [widthQ-1:0] q_sh;
    logic [widthX:0]   y_sh;
    logic [widthX:0]   acc;
    logic [CW-1:0]     cnt;
    logic              rem_ge_y;
    logic              accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nxt = BUSY;
            end
            BUSY: begin
                busy_o = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                // Result handshake and next acceptance may share one edge.
                in_ready_o  = out_ready_i;
                if (out_ready_i) state_nxt = in_valid_i ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid_i && in_ready_o;

    // Q shifts right while Y shifts left, so bit k of Q meets Y << k.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_sh     <= '0;
            y_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            rem_ge_y <= 1'b0;
        end else if (accept) begin
            q_sh     <= Q_i;
            y_sh     <= {{(widthX + 1 - widthY){1'b0}}, Y_i};
            acc      <= {{(widthX + 1 - widthY){1'b0}}, R_i};
            cnt      <= '0;
            rem_ge_y <= (R_i >= Y_i);
        end else if (state == BUSY) begin
            if (q_sh[0]) acc <= acc + y_sh;
            y_sh <= y_sh << 1;
            q_sh <= q_sh >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

    assign X_o        = acc;
    assign ovf_o      = acc[widthX];
    assign rem_ge_y_o = rem_ge_y;

endmodule

// File: tb/tb_mul_add_seq_uns.sv
// tb/tb_mul_add_seq_uns.sv - scoreboard bench for mul_add_seq_uns
module tb_mul_add_seq_uns;

    localparam int WX = 16;
    localparam int WY = 8;
    localparam int WQ = WX - WY + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WQ-1:0] q_in = '0;
    logic [WY-1:0] y_in = '0;
    logic [WY-1:0] r_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WX:0]   x_out;
    logic          ovf;
    logic          rem_ge_y;
    logic          busy;

    typedef struct {
        logic [WX:0] x;
        logic        ovf;
        logic        rge;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    mul_add_seq_uns #(.widthX(WX), .widthY(WY)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .Q_i(q_in), .Y_i(y_in), .R_i(r_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .X_o(x_out), .ovf_o(ovf), .rem_ge_y_o(rem_ge_y), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WQ-1:0] q, input logic [WY-1:0] y, input logic [WY-1:0] r);
        exp_t e;
        e.x   = (WX+1)'(q) * (WX+1)'(y) + (WX+1)'(r);
        e.ovf = e.x[WX];
        e.rge = (r >= y);
        return e;
    endfunction

    task automatic send(input logic [WQ-1:0] q, input logic [WY-1:0] y, input logic [WY-1:0] r, output bit ok);
        int n = 0;
        q_in = q; y_in = y; r_in = r; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk);
            sb.push_back(model(q, y, r));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, busy, x_out, ovf, rem_ge_y} !== {1'b1, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b x=%h ovf=%b rge=%b", in_ready, out_valid, busy, x_out, ovf, rem_ge_y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        bit ok; int lat; exp_t e;
        out_ready = 1'b1;
        send(9'h0AB, 8'h80, 8'h05, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nominal_accept got 0 expected 1"); end
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL nominal_latency got %0d expected 9", lat); end
        e = sb.pop_front();
        checks++;
        if (x_out !== e.x || x_out !== 17'h05585) begin errors++; $display("FAIL nominal_x got %h expected %h", x_out, e.x); end
        checks++;
        if (ovf !== 1'b0 || rem_ge_y !== 1'b0) begin errors++; $display("FAIL nominal_flags got ovf=%b rge=%b expected 0 0", ovf, rem_ge_y); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nominal_pulse got vld=%b expected 0", out_valid); end
    endtask

    task automatic test_max;
        bit ok; int lat; exp_t e;
        send(9'h1FF, 8'hFF, 8'hFF, ok);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (!ok || !out_valid || x_out !== e.x || x_out !== 17'h1FE00) begin
            errors++; $display("FAIL max_x got %h vld=%b expected %h", x_out, out_valid, e.x);
        end
        checks++;
        if (ovf !== 1'b1 || rem_ge_y !== 1'b1) begin errors++; $display("FAIL max_flags got ovf=%b rge=%b expected 1 1", ovf, rem_ge_y); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit ok; int lat; exp_t e; logic [WX:0] held;
        out_ready = 1'b0;
        send(9'h123, 8'h45, 8'h10, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat !== 9) begin errors++; $display("FAIL bp_first_latency got %0d expected 9", lat); end
        held = x_out;
        q_in = '0; y_in = 8'hC3; r_in = 8'h7F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (x_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stall got x=%h vld=%b rdy=%b expected x=%h vld=1 rdy=0", x_out, out_valid, in_ready, held);
            end
        end
        out_ready = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if (x_out !== e.x || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_x got %h rdy=%b expected %h rdy=1", x_out, in_ready, e.x); end
        @(posedge clk);
        sb.push_back(model('0, 8'hC3, 8'h7F));
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_same_edge got busy=%b vld=%b expected 1 0", busy, out_valid); end
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 9 || x_out !== e.x || x_out !== 17'h0007F) begin
            errors++; $display("FAIL bp_second got x=%h lat=%0d expected 0007f lat 9", x_out, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_div;
        bit ok; int lat; exp_t e;
        send(9'h1FF, 8'h00, 8'h12, ok);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (!ok || lat !== 9 || x_out !== e.x || x_out !== 17'h00012 || rem_ge_y !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL zero_div got x=%h rge=%b lat=%0d expected 00012 rge=1", x_out, rem_ge_y, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok; int lat; exp_t e; int pulses = 0;
        send(9'h0AB, 8'h80, 8'h05, ok);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({in_ready, out_valid, busy, x_out, ovf, rem_ge_y} !== {1'b1, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_async got rdy=%b vld=%b busy=%b x=%h", in_ready, out_valid, busy, x_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL reset_no_pulse got %0d expected 0", pulses); end
        send(9'h055, 8'hA7, 8'h33, ok);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (!ok || lat !== 9 || x_out !== e.x) begin errors++; $display("FAIL reset_recover got %h expected %h", x_out, e.x); end
        @(negedge clk);
    endtask

    task automatic test_random;
        bit ok; int lat; exp_t e;
        logic [WX-1:0] x; logic [WY-1:0] y; logic [WQ-1:0] q; logic [WY-1:0] r;
        for (int i = 0; i < 1000; i++) begin
            x = WX'($urandom_range(0, 65535));
            y = WY'($urandom_range(128, 255));
            q = WQ'(x / y);
            r = WY'(x % y);
            send(q, y, r, ok);
            wait_valid(lat);
            e = sb.pop_front();
            checks++;
            if (!ok || !out_valid || x_out !== e.x || x_out !== {1'b0, x} || ovf !== 1'b0 || rem_ge_y !== 1'b0) begin
                errors++; $display("FAIL random_%0d got x=%h ovf=%b rge=%b expected %h 0 0", i, x_out, ovf, rem_ge_y, x);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_max();
        test_back_to_back();
        test_zero_div();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
